time_trans: RTL and testbench
=============================

Name: time_trans

Overview:
- Drives a multiplexed 4-digit common-anode 7-segment display showing the traffic-light countdown (0–31 s) as two decimal digits.
- Sits between the countdown/state controller, which supplies `countdown_time`, and the board display pins.
- Digit 0 shows units and digit 1 shows tens. Digits 2 and 3 are scanned but blank.
- Fully synchronous to `clk`, except for the asynchronous active-low reset.

Parameters:
- SCAN_DIV, 50000, number of `clk` cycles each digit stays selected (≈1 kHz per digit at 50 MHz); legal range ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- countdown_time  input  5  remaining seconds, unsigned binary 0..31.
- sm_wei  output  4  digit select, active-low, one-cold; bit0 = digit 0 (rightmost).
- sm_duan  output  8  segment drive, active-low; bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- One clock and one reset. `rst_n` low asynchronously clears every register.
- Reset values:
  - `sm_wei` = 4'b1111 (all digits off).
  - `sm_duan` = 8'hFF (all segments off).
  - Divider counter = 0, digit index = 0, captured value = 0.
- Input capture: `val_q` <= `countdown_time` every clock.
- Binary to BCD is combinational from `val_q`:
  - tens = `val_q` / 10 (range 0..3).
  - units = `val_q` % 10.
  - All 5-bit inputs are legal; there is no out-of-range case.
- Scan divider: counter runs 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it returns to 0 and the 2-bit digit index increments.
  - The index wraps 3→0.
- Output registers update every clock from the current index and `val_q`:
  - index 0: `sm_wei` = 4'b1110, `sm_duan` = seg(units).
  - index 1: `sm_wei` = 4'b1101, `sm_duan` = seg(tens). The leading zero is shown, not blanked.
  - index 2: `sm_wei` = 4'b1011, `sm_duan` = 8'hFF.
  - index 3: `sm_wei` = 4'b0111, `sm_duan` = 8'hFF.
- seg() encoding (active-low, dp always off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Latency:
  - Input change to `sm_duan` = 2 clocks, provided the relevant digit is selected.
  - Index change to `sm_wei`/`sm_duan` = 1 clock.
- Exactly one `sm_wei` bit is low at any time after the first clock edge following reset release.
- `sm_wei` and `sm_duan` always change on the same edge, so no mismatched digit/segment pair ever appears.
- Reset asserted mid-scan: outputs go to FFh/1111 immediately, without waiting for a clock. After release, scanning restarts at digit 0 with a full SCAN_DIV dwell.
- An input change mid-dwell is reflected within the same dwell, 2 clocks later. No glitch filtering is applied.

Test Plan:
- Use SCAN_DIV=4 throughout.
- Reset: hold `rst_n`=0 with `countdown_time`=0 → `sm_wei`=1111, `sm_duan`=FF, including with no clock running. Release → after 1st edge `sm_wei`=1110, `sm_duan`=C0.
- `countdown_time`=25:
  - digit 0 window: 1110/92.
  - then 4 clocks of 1101/A4.
  - then 4 clocks of 1011/FF.
  - then 4 clocks of 0111/FF.
  - then back to 1110/92.
- Boundaries: value 0 → units C0, tens C0; 9 → 90/C0; 10 → C0/F9; 31 → F9/B0; 30 → C0/B0.
- Mid-dwell change: during the digit-0 window, switch 17→16 → `sm_duan` goes F8→82 exactly 2 clocks after the input edge, and `sm_wei` stays 1110.
- Reset pulse during the digit-2 window → outputs FF/1111 asynchronously; after release, the scan starts at digit 0 and each of the 4 digits holds exactly 4 clocks.
- Sweep 0..31 holding each value ≥16 clocks → sampled units/tens match value%10 and value/10 decoded per the table. The one-cold `sm_wei` invariant holds on every cycle.

Source files
------------

// File: rtl/time_trans.sv
// Scans a 2-digit decimal countdown (0..31) onto a 4-digit common-anode
// 7-segment display; digits 2 and 3 are scanned but always blank.
module time_trans #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] countdown_time,
  output logic [3:0] sm_wei,
  output logic [7:0] sm_duan
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    val_q, val_d;
  logic [3:0]    wei_q, wei_d;
  logic [7:0]    duan_q, duan_d;
  logic [3:0]    tens, units;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp stays off.
  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  always_comb begin
    tens  = 4'(val_q / 5'd10);
    units = 4'(val_q % 5'd10);
  end

  always_comb begin
    val_d = countdown_time;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Select and segments come from the same index, so they always move together.
  always_comb begin
    wei_d  = 4'b1111;
    duan_d = 8'hFF;
    case (idx_q)
      2'd0: begin
        wei_d  = 4'b1110;
        duan_d = seg(units);
      end
      2'd1: begin
        wei_d  = 4'b1101;
        duan_d = seg(tens);
      end
      2'd2: wei_d = 4'b1011;
      default: wei_d = 4'b0111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      val_q  <= 5'd0;
      wei_q  <= 4'b1111;
      duan_q <= 8'hFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      val_q  <= val_d;
      wei_q  <= wei_d;
      duan_q <= duan_d;
    end
  end

  assign sm_wei  = wei_q;
  assign sm_duan = duan_q;

endmodule

// File: tb/tb_time_trans.sv
// Bench for time_trans: directed reset/boundary scenarios plus randomized
// sweeps checked against a digit-window reference model.
module tb_time_trans;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [4:0] countdown_time;
  logic [3:0] sm_wei;
  logic [7:0] sm_duan;

  int checks;
  int errors;
  logic chk_en;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  time_trans #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .countdown_time (countdown_time),
    .sm_wei         (sm_wei),
    .sm_duan        (sm_duan)
  );

  // Clock / reset block: the clock can be held still to observe async reset.
  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: after the k-th edge since reset release, the display
  // shows digit ((k-1)/SCAN_DIV)%4 of the value sampled one edge earlier.
  int         edges;
  int         mval;
  logic [3:0] exp_wei;
  logic [7:0] exp_duan;

  function automatic logic [3:0] wei_for(input int e);
    logic [3:0] w;
    w = 4'hF;
    w[(e / SCAN_DIV) % 4] = 1'b0;
    return w;
  endfunction

  function automatic logic [7:0] duan_for(input int e, input int v);
    case ((e / SCAN_DIV) % 4)
      0:       return seg_tab[v % 10];
      1:       return seg_tab[v / 10];
      default: return 8'hFF;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges    <= 0;
      mval     <= 0;
      exp_wei  <= 4'hF;
      exp_duan <= 8'hFF;
    end else begin
      exp_wei  <= wei_for(edges);
      exp_duan <= duan_for(edges, mval);
      mval     <= int'(countdown_time);
      edges    <= edges + 1;
    end
  end

  // Scoreboard: compare every cycle on the inactive edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wei", 32'(sm_wei), 32'(exp_wei));
      check("duan", 32'(sm_duan), 32'(exp_duan));
      if (exp_wei != 4'hF)
        check("onecold", 32'($countones(~sm_wei)), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_low();
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    countdown_time = 5'd0;

    // Reset with no clock running.
    #1 rst_n = 1'b0;
    #20;
    check("rst_noclk_wei", 32'(sm_wei), 32'h0000000F);
    check("rst_noclk_duan", 32'(sm_duan), 32'h000000FF);

    clk_en = 1'b1;
    chk_en = 1'b1;
    repeat (3) mid_low();
    rst_n = 1'b1;
    tick();
    check("first_wei", 32'(sm_wei), 32'h0000000E);
    check("first_duan", 32'(sm_duan), 32'h000000C0);

    // Value 25 through several full scans.
    countdown_time = 5'd25;
    repeat (40) tick();

    // Mid-dwell change 17 -> 16 in the digit-0 window.
    mid_low();
    rst_n = 1'b0;
    countdown_time = 5'd17;
    repeat (2) mid_low();
    rst_n = 1'b1;
    tick();
    tick();
    check("md_f8", 32'(sm_duan), 32'h000000F8);
    countdown_time = 5'd16;
    tick();
    check("md_hold", 32'(sm_duan), 32'h000000F8);
    tick();
    check("md_82", 32'(sm_duan), 32'h00000082);
    check("md_wei", 32'(sm_wei), 32'h0000000E);

    // Reset pulse while digit 2 is showing.
    begin
      int n;
      n = 0;
      while (sm_wei !== 4'b1011 && n < 40) begin
        tick();
        n++;
      end
      check("find_dig2", 32'(sm_wei), 32'h0000000B);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_wei", 32'(sm_wei), 32'h0000000F);
    check("async_duan", 32'(sm_duan), 32'h000000FF);
    repeat (2) mid_low();
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] w;
      tick();
      w = 4'hF;
      w[k / 4] = 1'b0;
      check("dwell", 32'(sm_wei), 32'(w));
    end

    // Sweep every value, held for a random stretch.
    for (int v = 0; v < 32; v++) begin
      countdown_time = 5'(v);
      repeat (16 + $urandom_range(0, 6)) tick();
    end

    // Random input changes, including mid-dwell.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        countdown_time = 5'($urandom_range(0, 31));
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
